// File: rtl/if_stage.sv
// LA32R instruction-fetch stage: fetch PC, synchronous IROM addressing,
// response realignment and the IF/ID register with a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] irom_adr,
    input  logic [31:0]       irom_inst,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic [31:0]       id_inst
);

    logic        issue;

    logic [31:0] pc_q, pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;

    assign issue = !flush && !stall;

    // Redirect targets are word-aligned by masking the low bits.
    always_comb begin
        pc_d         = pc_q;
        resp_valid_d = issue;
        resp_pc_d    = pc_q;
        if (flush) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // IF/ID and skid update: flush beats stall, skid drains before the live response.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        if (flush) begin
            id_valid_d   = 1'b0;
            id_inst_d    = 32'h0;
            skid_valid_d = 1'b0;
        end else if (stall) begin
            if (resp_valid_q) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = resp_pc_q;
                skid_inst_d  = irom_inst;
            end
        end else if (skid_valid_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = skid_pc_q;
            id_inst_d  = skid_inst_q;
            if (resp_valid_q) begin
                skid_pc_d   = resp_pc_q;
                skid_inst_d = irom_inst;
            end else begin
                skid_valid_d = 1'b0;
            end
        end else if (resp_valid_q) begin
            id_valid_d = 1'b1;
            id_pc_d    = resp_pc_q;
            id_inst_d  = irom_inst;
        end else begin
            id_valid_d = 1'b0;
            id_inst_d  = 32'h0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_inst_q  <= 32'h0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'h0;
            id_inst_q    <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
        end
    end

    assign irom_adr = pc_q[ADDR_W+1:2];
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_pc4   = id_pc_q + 32'd4;
    assign id_inst  = id_inst_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the LA32R five-stage pipeline.
- Holds the fetch PC and drives the synchronous instruction ROM.
- Realigns the 1-cycle ROM response and registers it into the IF/ID pipeline register.
- The decode stage takes id_inst[31:15] as the control-unit opcode input. A one-entry skid buffer guarantees no instruction is lost or duplicated across stalls.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset.
- ADDR_W, 14, IROM word-address width.

Ports:
- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; hold IF/ID and suppress new fetch issue.
- flush  in  1  from EX; taken branch/jump, redirect fetch.
- redirect_pc  in  32  target PC, meaningful only when flush=1.
- irom_adr  out  ADDR_W  IROM word address = pc_f[ADDR_W+1:2].
- irom_inst  in  32  IROM data, valid the cycle after the address is presented.
- id_valid  out  1  IF/ID entry holds a real instruction.
- id_pc  out  32  PC of the IF/ID instruction.
- id_pc4  out  32  id_pc+4 (combinational from id_pc).
- id_inst  out  32  instruction word; 32'h0 when id_valid=0.

Behaviour:
- Clocking/reset: one clock, cpu_clk. cpu_rst is asynchronous and active-high. On reset:
  - pc_f=RESET_PC.
  - resp_valid=0, resp_pc=0.
  - skid_valid=0, skid_pc=0, skid_inst=0.
  - id_valid=0, id_pc=0, id_inst=0.
  - irom_adr therefore shows RESET_PC[ADDR_W+1:2].
- Issue: issue = !flush && !stall, evaluated each cycle. Fetch-PC update at the edge:
  - flush: pc_f <= {redirect_pc[31:2],2'b00}.
  - else if issue: pc_f <= pc_f+4, 32-bit wrap, no exception.
  - else: hold.
- Response tracking, at the edge: resp_valid <= issue; resp_pc <= pc_f. The cycle after issue, irom_inst belongs to resp_pc. With resp_valid=0, irom_inst is ignored.
- IF/ID update at the edge, in priority order:
  1. flush: id_valid<=0, id_inst<=0, skid_valid<=0. Flush overrides stall.
  2. stall: IF/ID holds. If resp_valid=1, capture {resp_pc, irom_inst} into the skid buffer and set skid_valid<=1. resp_valid=1 with skid_valid=1 cannot occur under stall, since no issue happens while stalled; the bench asserts this.
  3. Not stalled, skid_valid=1: IF/ID <= skid entry, id_valid<=1. If resp_valid=1 as well, resp moves into skid (skid_valid stays 1); otherwise skid_valid<=0.
  4. Not stalled, resp_valid=1: IF/ID <= {resp_pc, irom_inst}, id_valid<=1.
  5. Otherwise: bubble, id_valid<=0, id_inst<=0.
- Latency:
  - Address presented in cycle N reaches IF/ID at the end of cycle N+1.
  - After reset release, the first valid id_pc=RESET_PC is visible in the cycle after the second edge.
  - After a flush edge: exactly two bubbles, then id_pc=redirect target.
- Stall release: no bubble. The skid entry enters ID at the first unstalled edge; the fetch issued that cycle follows on the next edge.
- Throughput: one instruction per cycle when stall=flush=0.
- redirect_pc[1:0] are ignored and forced to 0. No misalignment exception in this block.
- Reset mid-stall or mid-flush: the asynchronous clear wins immediately; the skid contents are discarded.

Test Plan:
- Reset, then IROM word k = 32'h0280_0000|k, no stall → irom_adr 0,1,2…; id_pc 1C000000, 1C000004, … back-to-back; id_inst matches word; id_pc4 = id_pc+4.
- stall high 3 cycles while id_pc=1C000008 → ID holds 1C000008 for 4 cycles total; after release 1C00000C, 1C000010 with no gap, no duplicate.
- flush with redirect_pc=1C000100 while streaming → next two cycles id_valid=0/id_inst=0; then id_pc=1C000100, 1C000104.
- flush and stall same cycle with skid full → skid discarded; id_valid=0; target fetched as in the flush scenario.
- redirect_pc=1C000203 → irom_adr=0x080; id_pc=1C000200.
- Assert cpu_rst asynchronously mid-stall with skid full → outputs zero immediately without waiting for an edge; after release, fetch restarts at RESET_PC.
- Bench assertion: skid_valid=1 and resp_valid=1 never both true while stall=1.
